seg_scan_driver: RTL and testbench

Time-multiplexed driver for a common-anode, multi-digit seven-segment display: takes a packed hex value, decimal-point and blank masks, and scans one digit at a time. It owns the hex-to-glyph decode, a refresh prescaler, anti-ghosting guard time, leading-zero suppression and frame-synchronous double-buffering. It sits between the datapath status registers and the board display pins.

---
 rtl/seg_scan_if.sv | 25 ++
 rtl/seg_scan_driver.sv | 172 +++++++++++++++++
 tb/tb_seg_scan_driver.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/seg_scan_if.sv
// Display-side bundle for seg_scan_driver: buffered data inputs plus scan outputs.
// Ports: load/value/dp/blank/lz_en into the driver; segs/dp_n/an_n/frame out of it.
interface seg_scan_if #(
    parameter int DIGITS = 4
);
    logic                  load;
    logic [4*DIGITS-1:0]   value;
    logic [DIGITS-1:0]     dp;
    logic [DIGITS-1:0]     blank;
    logic                  lz_en;
    logic [6:0]            segs;
    logic                  dp_n;
    logic [DIGITS-1:0]     an_n;
    logic                  frame;

    modport master (
        output load, value, dp, blank, lz_en,
        input  segs, dp_n, an_n, frame
    );

    modport slave (
        input  load, value, dp, blank, lz_en,
        output segs, dp_n, an_n, frame
    );
endinterface

// File: rtl/seg_scan_driver.sv
// Time-multiplexed common-anode seven-segment scanner with guard time,
// leading-zero suppression and frame-synchronous double buffering.
// Ports: clk, rst_n (sync, active low); bus (slave) carries load/value/dp/
// blank/lz_en in and segs/dp_n/an_n/frame out (all outputs registered).
module seg_scan_driver #(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 50000,
    parameter int GUARD    = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    seg_scan_if.slave  bus
);
    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    // Slot timing
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic                wrap, frame_start;

    // Pending and display buffers
    logic [4*DIGITS-1:0] pend_val_q, pend_val_d;
    logic [DIGITS-1:0]   pend_dp_q, pend_dp_d;
    logic [DIGITS-1:0]   pend_blank_q, pend_blank_d;
    logic                pend_valid_q, pend_valid_d;
    logic [4*DIGITS-1:0] disp_val_q, disp_val_d;
    logic [DIGITS-1:0]   disp_dp_q, disp_dp_d;
    logic [DIGITS-1:0]   disp_blank_q, disp_blank_d;

    // Registered outputs
    logic [6:0]          segs_q, segs_d;
    logic                dp_n_q, dp_n_d;
    logic [DIGITS-1:0]   an_q, an_d;
    logic                fs_q, frame_q;

    logic [DIGITS-1:0]   lz_dark;
    logic                lz_run;
    logic                dark, lit;
    logic [3:0]          nib;

    function automatic logic [6:0] glyph(input logic [3:0] h);
        logic [6:0] g;
        unique case (h)
            4'h0: g = 7'h01;
            4'h1: g = 7'h4F;
            4'h2: g = 7'h12;
            4'h3: g = 7'h06;
            4'h4: g = 7'h4C;
            4'h5: g = 7'h24;
            4'h6: g = 7'h20;
            4'h7: g = 7'h0F;
            4'h8: g = 7'h00;
            4'h9: g = 7'h0C;
            4'hA: g = 7'h08;
            4'hB: g = 7'h60;
            4'hC: g = 7'h31;
            4'hD: g = 7'h42;
            4'hE: g = 7'h30;
            default: g = 7'h38;
        endcase
        return g;
    endfunction

    assign wrap        = (cnt_q == CW'(PRESCALE - 1));
    assign frame_start = wrap && (idx_q == IW'(DIGITS - 1));

    always_comb begin
        cnt_d = wrap ? '0 : cnt_q + 1'b1;
        idx_d = idx_q;
        if (wrap) begin
            idx_d = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end
    end

    // A load landing on the frame-start cycle bypasses the pending
    // buffer so it is shown in the frame that is just beginning.
    always_comb begin
        pend_val_d   = pend_val_q;
        pend_dp_d    = pend_dp_q;
        pend_blank_d = pend_blank_q;
        pend_valid_d = pend_valid_q;
        disp_val_d   = disp_val_q;
        disp_dp_d    = disp_dp_q;
        disp_blank_d = disp_blank_q;
        if (bus.load) begin
            pend_val_d   = bus.value;
            pend_dp_d    = bus.dp;
            pend_blank_d = bus.blank;
        end
        if (frame_start) begin
            pend_valid_d = 1'b0;
            if (bus.load) begin
                disp_val_d   = bus.value;
                disp_dp_d    = bus.dp;
                disp_blank_d = bus.blank;
            end else if (pend_valid_q) begin
                disp_val_d   = pend_val_q;
                disp_dp_d    = pend_dp_q;
                disp_blank_d = pend_blank_q;
            end
        end else if (bus.load) begin
            pend_valid_d = 1'b1;
        end
    end

    // Digit i is a leading zero when it and every more significant
    // nibble are zero; digit 0 is never treated as leading.
    always_comb begin
        lz_dark = '0;
        lz_run  = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            lz_run     = lz_run && (disp_val_q[4*i +: 4] == 4'h0);
            lz_dark[i] = lz_run;
        end
    end

    always_comb begin
        nib    = disp_val_q[4*idx_q +: 4];
        dark   = disp_blank_q[idx_q] || (bus.lz_en && lz_dark[idx_q]);
        lit    = !dark && (int'(cnt_q) >= GUARD);
        an_d   = '1;
        segs_d = 7'h7F;
        dp_n_d = 1'b1;
        if (lit) begin
            an_d[idx_q] = 1'b0;
            segs_d      = glyph(nib);
            dp_n_d      = ~disp_dp_q[idx_q];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            pend_val_q   <= '0;
            pend_dp_q    <= '0;
            pend_blank_q <= '0;
            pend_valid_q <= 1'b0;
            disp_val_q   <= '0;
            disp_dp_q    <= '0;
            disp_blank_q <= '1;
            segs_q       <= 7'h7F;
            dp_n_q       <= 1'b1;
            an_q         <= '1;
            fs_q         <= 1'b0;
            frame_q      <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            pend_val_q   <= pend_val_d;
            pend_dp_q    <= pend_dp_d;
            pend_blank_q <= pend_blank_d;
            pend_valid_q <= pend_valid_d;
            disp_val_q   <= disp_val_d;
            disp_dp_q    <= disp_dp_d;
            disp_blank_q <= disp_blank_d;
            segs_q       <= segs_d;
            dp_n_q       <= dp_n_d;
            an_q         <= an_d;
            // fs_q marks the first cycle of slot 0; frame follows one
            // register later so it lines up with that slot's outputs.
            fs_q         <= frame_start;
            frame_q      <= fs_q;
        end
    end

    assign bus.segs  = segs_q;
    assign bus.dp_n  = dp_n_q;
    assign bus.an_n  = an_q;
    assign bus.frame = frame_q;
endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver.
// Reference model predicts each output word.
module tb_seg_scan_driver;
  localparam int D = 4;
  localparam int P = 8;
  localparam int G = 2;
  localparam int FP = D * P;
  localparam logic [6:0] GLY [16] = '{
    7'h01, 7'h4F, 7'h12, 7'h06,
    7'h4C, 7'h24, 7'h20, 7'h0F,
    7'h00, 7'h0C, 7'h08, 7'h60,
    7'h31, 7'h42, 7'h30, 7'h38
  };

  logic clk = 1'b0;
  logic rst_n;
  seg_scan_if #(.DIGITS(D)) bus ();

  seg_scan_driver #(
    .DIGITS(D), .PRESCALE(P), .GUARD(G)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  int          mk = 0;
  logic [15:0] dval = '0, pval = '0;
  logic [3:0]  ddp = '0, dblank = '1;
  logic [3:0]  pdp = '0, pblank = '0;
  bit          pvalid = 0;
  logic [12:0] q [$];

  always @(posedge clk) begin
    int cnt, idx;
    bit dark, lit;
    logic [3:0] an;
    logic [6:0] sg;
    logic dpn, fr;
    if (!rst_n) begin
      q.push_back({4'hF, 7'h7F, 1'b1, 1'b0});
      mk = 0; dval = '0; ddp = '0;
      dblank = '1; pvalid = 0;
    end else begin
      cnt  = mk % P;
      idx  = (mk / P) % D;
      dark = dblank[idx] ||
             (bus.lz_en && idx != 0 &&
              (dval >> (4 * idx)) == 16'h0);
      lit  = !dark && cnt >= G;
      an = 4'hF; sg = 7'h7F; dpn = 1'b1;
      if (lit) begin
        an[idx] = 1'b0;
        sg  = GLY[(dval >> (4 * idx)) & 16'hF];
        dpn = ~ddp[idx];
      end
      fr = (mk > 0) && (mk % FP == 0);
      q.push_back({an, sg, dpn, fr});
      if (mk % FP == FP - 1) begin
        if (bus.load) begin
          dval = bus.value; ddp = bus.dp;
          dblank = bus.blank;
        end else if (pvalid) begin
          dval = pval; ddp = pdp;
          dblank = pblank;
        end
        pvalid = 0;
      end else if (bus.load) begin
        pvalid = 1;
      end
      if (bus.load) begin
        pval = bus.value; pdp = bus.dp;
        pblank = bus.blank;
      end
      mk++;
    end
  end

  always @(negedge clk) begin
    logic [12:0] exp_w, act_w;
    if (q.size() > 0) begin
      exp_w = q.pop_front();
      act_w = {bus.an_n, bus.segs,
               bus.dp_n, bus.frame};
      n_checks++;
      if (act_w !== exp_w) begin
        n_fail++;
        $display("FAIL outputs t=%0t mk=%0d got %h want %h",
                 $time, mk, act_w, exp_w);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [15:0] v,
                         input logic [3:0] p,
                         input logic [3:0] b);
    bus.load = 1'b1; bus.value = v;
    bus.dp = p; bus.blank = b;
    tick(1);
    bus.load = 1'b0;
  endtask

  task automatic wait_phase(input int ph);
    for (int i = 0; i < 4 * FP; i++) begin
      if (mk % FP == ph) return;
      tick(1);
    end
    n_checks++;
    n_fail++;
    $display("FAIL wait_phase timeout mk=%0d ph=%0d",
             mk, ph);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.load = 1'b0; bus.value = '0; bus.dp = '0;
    bus.blank = '0; bus.lz_en = 1'b0;
    tick(3);
    #1;
    n_checks++;
    if (bus.an_n !== 4'hF) begin
      n_fail++;
      $display("FAIL reset an_n=%b want 1111", bus.an_n);
    end
    n_checks++;
    if (bus.segs !== 7'h7F) begin
      n_fail++;
      $display("FAIL reset segs=%h want 7f", bus.segs);
    end
    n_checks++;
    if (bus.dp_n !== 1'b1) begin
      n_fail++;
      $display("FAIL reset dp_n=%b want 1", bus.dp_n);
    end
    n_checks++;
    if (bus.frame !== 1'b0) begin
      n_fail++;
      $display("FAIL reset frame=%b want 0", bus.frame);
    end
    rst_n = 1'b1;
    tick(40);
    #1;
    n_checks++;
    if (bus.an_n !== 4'hF) begin
      n_fail++;
      $display("FAIL dark after reset an_n=%b want 1111",
               bus.an_n);
    end

    do_load(16'h1234, 4'b0010, 4'b0000);
    tick(80);

    bus.lz_en = 1'b1;
    do_load(16'h0050, 4'b0000, 4'b0000);
    tick(70);
    do_load(16'h0000, 4'b0000, 4'b0000);
    tick(70);
    bus.lz_en = 1'b0;
    tick(40);

    wait_phase(10);
    do_load(16'hAAAA, 4'b0000, 4'b0000);
    tick(5);
    do_load(16'hBBBB, 4'b1001, 4'b0000);
    tick(50);
    wait_phase(FP - 1);
    do_load(16'hCDEF, 4'b0100, 4'b0000);
    tick(40);

    do_load(16'h8888, 4'b1111, 4'b0101);
    tick(70);

    wait_phase(2);
    do_load(16'h5678, 4'b0000, 4'b0000);
    wait_phase(18);
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(70);

    for (int i = 0; i < 1500; i++) begin
      bus.load  = ($urandom_range(0, 9) == 0);
      bus.value = 16'($urandom);
      bus.dp    = 4'($urandom);
      bus.blank = ($urandom_range(0, 3) == 0) ?
                  4'($urandom) : 4'h0;
      if ($urandom_range(0, 49) == 0)
        bus.lz_en = ~bus.lz_en;
      rst_n = ($urandom_range(0, 399) != 0);
      tick(1);
    end
    bus.load = 1'b0;
    rst_n = 1'b1;
    tick(40);

    @(posedge clk);
    @(negedge clk);
    #1;
    n_checks++;
    if (n_fail != 0)
      $display("FAIL total failures %0d", n_fail);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end
endmodule
